// File: rtl/cpu_pkg.sv
// Shared CPU front-end types: bus widths, the fetch queue entry and the fetch FSM states.
package cpu_pkg;

   localparam int ADDR_W  = 32;
   localparam int INSTR_W = 32;

   typedef struct packed {
      logic [ADDR_W-1:0]  pc;
      logic [INSTR_W-1:0] instr;
   } fetch_entry_t;

   typedef enum logic [1:0] {
      BOOT,
      FETCH,
      HOLD
   } fetch_state_t;

   // Redirect targets are word aligned by dropping the two byte-offset bits.
   function automatic logic [ADDR_W-1:0] align_pc(input logic [ADDR_W-1:0] pc);
      return pc & ~{{(ADDR_W-2){1'b0}}, 2'b11};
   endfunction

endpackage

// File: rtl/fetch_queue.sv
// Two-entry FIFO of {pc, instr} pairs between instruction memory and the core.
module fetch_queue
   import cpu_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic               push,
   input  logic [ADDR_W-1:0]  push_pc,
   input  logic [INSTR_W-1:0] push_instr,
   input  logic               pop,
   input  logic               flush,
   output logic [1:0]         count,
   output logic [ADDR_W-1:0]  head_pc,
   output logic [INSTR_W-1:0] head_instr
);

   fetch_entry_t entries [2];
   logic         rd_ptr;
   logic         wr_ptr;
   logic [1:0]   count_q;

   // Flush only rewinds the pointers; stale payload is never presented because count drops to 0.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         entries[0] <= '0;
         entries[1] <= '0;
         rd_ptr     <= 1'b0;
         wr_ptr     <= 1'b0;
         count_q    <= 2'd0;
      end else if (flush) begin
         rd_ptr  <= 1'b0;
         wr_ptr  <= 1'b0;
         count_q <= 2'd0;
      end else begin
         if (push) begin
            entries[wr_ptr] <= '{pc: push_pc, instr: push_instr};
            wr_ptr          <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         count_q <= count_q + {1'b0, push} - {1'b0, pop};
      end
   end

   assign count      = count_q;
   assign head_pc    = entries[rd_ptr].pc;
   assign head_instr = entries[rd_ptr].instr;

endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction-fetch front end: PC, credit-limited request FSM, response kill and output queue.
// Optional FETCH_ALIGN_CHECK_EN reports unaligned redirect targets on misalign_fault.
module pc_fetch_unit
   import cpu_pkg::*;
#(
   parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000,
   parameter logic [ADDR_W-1:0] PC_STEP  = 32'd4
) (
   input  logic               clk,
   input  logic               reset,
   output logic               imem_req,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic [INSTR_W-1:0] imem_rdata,
   input  logic               redirect_valid,
   input  logic [ADDR_W-1:0]  redirect_pc,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [ADDR_W-1:0]  out_pc,
   output logic [INSTR_W-1:0] out_instr,
   output logic               misalign_fault
);

   fetch_state_t      state_q;
   logic [ADDR_W-1:0] fetch_pc_q;
   logic [ADDR_W-1:0] inflight_pc_q;
   logic              inflight_q;
   logic [1:0]        count;
   logic              pop;
   logic              push;
   logic [2:0]        occupancy;
   logic              credit_ok;

   assign out_valid = (count != 2'd0);
   assign pop       = out_valid & out_ready;

   // A slot freed by this cycle's pop can be re-used immediately, giving 1 instr/cycle streaming.
   assign occupancy = {1'b0, count} + {2'b00, inflight_q} - {2'b00, pop};
   assign credit_ok = (occupancy < 3'd2);

   assign imem_req  = (state_q != BOOT) & credit_ok & ~redirect_valid;
   assign imem_addr = fetch_pc_q;

   // A response returning in a redirect cycle belongs to the old path and is dropped.
   assign push = inflight_q & ~redirect_valid;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= BOOT;
         fetch_pc_q    <= RESET_PC;
         inflight_pc_q <= '0;
         inflight_q    <= 1'b0;
      end else if (redirect_valid) begin
         state_q    <= FETCH;
         fetch_pc_q <= align_pc(redirect_pc);
         inflight_q <= 1'b0;
      end else begin
         inflight_q <= imem_req;
         if (imem_req) begin
            inflight_pc_q <= fetch_pc_q;
            fetch_pc_q    <= fetch_pc_q + PC_STEP;
         end
         case (state_q)
            BOOT:        state_q <= FETCH;
            FETCH, HOLD: state_q <= credit_ok ? FETCH : HOLD;
            default:     state_q <= BOOT;
         endcase
      end
   end

   fetch_queue u_queue (
      .clk        (clk),
      .reset      (reset),
      .push       (push),
      .push_pc    (inflight_pc_q),
      .push_instr (imem_rdata),
      .pop        (pop),
      .flush      (redirect_valid),
      .count      (count),
      .head_pc    (out_pc),
      .head_instr (out_instr)
   );

`ifdef FETCH_ALIGN_CHECK_EN
   logic misalign_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         misalign_q <= 1'b0;
      end else begin
         misalign_q <= redirect_valid & (redirect_pc[1:0] != 2'b00);
      end
   end

   assign misalign_fault = misalign_q;
`else
   assign misalign_fault = 1'b0;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: reset vectors, hand-built corner sequences and a
// randomized run, all compared against a queue-based reference model of the fetch rules.
module tb_pc_fetch_unit;

`ifdef FETCH_ALIGN_CHECK_EN
   localparam bit ALIGN_CHK = 1'b1;
`else
   localparam bit ALIGN_CHK = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [31:0] out_instr;
   logic        misalign_fault;

   always #5 clk = ~clk;

   pc_fetch_unit dut (
      .clk            (clk),
      .reset          (reset),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_rdata     (imem_rdata),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_pc         (out_pc),
      .out_instr      (out_instr),
      .misalign_fault (misalign_fault)
   );

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } ent_t;

   typedef struct {
      logic        rdy;
      logic        expReq;
      logic [31:0] expAddr;
      logic        expValid;
      logic [31:0] expPc;
   } vec_t;

   int totalChecks  = 0;
   int passedChecks = 0;

   // Reference model state
   ent_t        mq[$];
   logic        mInflight;
   logic [31:0] mInflightPc;
   logic [31:0] mFetchPc;
   logic        mBoot;
   logic        mMis;

   // Outputs sampled in the most recent cycle
   logic        sReq;
   logic [31:0] sAddr;
   logic        sValid;
   logic [31:0] sPc;
   logic [31:0] sInstr;
   logic        sMis;

   // Instruction memory contents: a bijective scramble of the address.
   function automatic logic [31:0] memWord(input logic [31:0] a);
      return (a ^ 32'h5A5A_C3C3) + 32'h0000_1001;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      totalChecks++;
      if (act === exp) begin
         passedChecks++;
      end else begin
         $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic modelReset();
      mq.delete();
      mInflight   = 1'b0;
      mInflightPc = 32'h0;
      mFetchPc    = 32'h0;
      mBoot       = 1'b1;
      mMis        = 1'b0;
   endtask

   // One clock cycle: drive inputs after negedge, sample and check, advance the model.
   task automatic applyStimulus(input logic rdy, input logic rv, input logic [31:0] rpc);
      logic expValid;
      logic expReq;
      logic pop;
      int   occ;
      ent_t e;
      out_ready      = rdy;
      redirect_valid = rv;
      redirect_pc    = rpc;
      #1;
      sReq   = imem_req;
      sAddr  = imem_addr;
      sValid = out_valid;
      sPc    = out_pc;
      sInstr = out_instr;
      sMis   = misalign_fault;

      expValid = (mq.size() > 0);
      pop      = expValid && rdy;
      occ      = mq.size() + (mInflight ? 1 : 0) - (pop ? 1 : 0);
      expReq   = !mBoot && !rv && (occ < 2);

      checkOutput("imem_req", {31'b0, sReq}, {31'b0, expReq});
      if (expReq) checkOutput("imem_addr", sAddr, mFetchPc);
      checkOutput("out_valid", {31'b0, sValid}, {31'b0, expValid});
      if (expValid) begin
         checkOutput("out_pc", sPc, mq[0].pc);
         checkOutput("out_instr", sInstr, mq[0].instr);
      end
      checkOutput("misalign_fault", {31'b0, sMis}, {31'b0, mMis});

      if (rv) begin
         mq.delete();
         mInflight = 1'b0;
         mFetchPc  = rpc & 32'hFFFF_FFFC;
         mMis      = ALIGN_CHK && (rpc[1:0] != 2'b00);
      end else begin
         if (pop) void'(mq.pop_front());
         if (mInflight) begin
            e.pc    = mInflightPc;
            e.instr = memWord(mInflightPc);
            mq.push_back(e);
         end
         mInflight = expReq;
         if (expReq) begin
            mInflightPc = mFetchPc;
            mFetchPc    = mFetchPc + 32'd4;
         end
         mMis = 1'b0;
      end
      mBoot = 1'b0;

      @(posedge clk);
      #1;
      imem_rdata = sReq ? memWord(sAddr) : $urandom();
      @(negedge clk);
   endtask

   // Assert reset mid-cycle, check the immediate effect, release on a negedge.
   task automatic doReset();
      reset = 1'b0;
      #1;
      checkOutput("rst out_valid", {31'b0, out_valid}, 32'h0);
      checkOutput("rst imem_req", {31'b0, imem_req}, 32'h0);
      checkOutput("rst misalign", {31'b0, misalign_fault}, 32'h0);
      checkOutput("rst out_pc", out_pc, 32'h0);
      checkOutput("rst out_instr", out_instr, 32'h0);
      modelReset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
   endtask

   vec_t vecs[6];

   initial begin
      out_ready      = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      imem_rdata     = 32'h0;

      vecs[0] = '{1'b1, 1'b0, 32'h0,  1'b0, 32'h0};
      vecs[1] = '{1'b1, 1'b1, 32'h0,  1'b0, 32'h0};
      vecs[2] = '{1'b1, 1'b1, 32'h4,  1'b0, 32'h0};
      vecs[3] = '{1'b1, 1'b1, 32'h8,  1'b1, 32'h0};
      vecs[4] = '{1'b1, 1'b1, 32'hC,  1'b1, 32'h4};
      vecs[5] = '{1'b1, 1'b1, 32'h10, 1'b1, 32'h8};

      @(negedge clk);
      doReset();

      // Boot, then streaming at one instruction per cycle
      for (int i = 0; i < 6; i++) begin
         applyStimulus(vecs[i].rdy, 1'b0, 32'h0);
         checkOutput("vec req", {31'b0, sReq}, {31'b0, vecs[i].expReq});
         if (vecs[i].expReq) checkOutput("vec addr", sAddr, vecs[i].expAddr);
         checkOutput("vec valid", {31'b0, sValid}, {31'b0, vecs[i].expValid});
         if (vecs[i].expValid) begin
            checkOutput("vec pc", sPc, vecs[i].expPc);
            checkOutput("vec instr", sInstr, memWord(vecs[i].expPc));
         end
      end

      // Redirect with one queued entry and one response inflight
      applyStimulus(1'b1, 1'b1, 32'h100);
      checkOutput("redir R req", {31'b0, sReq}, 32'h0);
      applyStimulus(1'b1, 1'b0, 32'h0);
      checkOutput("redir R+1 req", {31'b0, sReq}, 32'h1);
      checkOutput("redir R+1 addr", sAddr, 32'h100);
      checkOutput("redir R+1 valid", {31'b0, sValid}, 32'h0);
      applyStimulus(1'b1, 1'b0, 32'h0);
      checkOutput("redir R+2 valid", {31'b0, sValid}, 32'h0);
      applyStimulus(1'b1, 1'b0, 32'h0);
      checkOutput("redir R+3 valid", {31'b0, sValid}, 32'h1);
      checkOutput("redir R+3 pc", sPc, 32'h100);
      applyStimulus(1'b1, 1'b0, 32'h0);
      checkOutput("redir R+4 pc", sPc, 32'h104);

      // Backpressure right after the first output, then release
      doReset();
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 32'h0);
      for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 32'h0);
      checkOutput("stall req", {31'b0, sReq}, 32'h0);
      checkOutput("stall valid", {31'b0, sValid}, 32'h1);
      checkOutput("stall pc", sPc, 32'h0);
      for (int k = 0; k < 6; k++) begin
         applyStimulus(1'b1, 1'b0, 32'h0);
         checkOutput("resume valid", {31'b0, sValid}, 32'h1);
         checkOutput("resume pc", sPc, 32'(4 * k));
      end

      // Reset while the queue is full
      for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 32'h0);
      doReset();
      applyStimulus(1'b1, 1'b0, 32'h0);
      checkOutput("reboot boot req", {31'b0, sReq}, 32'h0);
      applyStimulus(1'b1, 1'b0, 32'h0);
      checkOutput("reboot req", {31'b0, sReq}, 32'h1);
      checkOutput("reboot addr", sAddr, 32'h0);

      // Address wrap at the top of memory
      applyStimulus(1'b1, 1'b1, 32'hFFFF_FFF8);
      applyStimulus(1'b1, 1'b0, 32'h0);
      checkOutput("wrap addr0", sAddr, 32'hFFFF_FFF8);
      applyStimulus(1'b1, 1'b0, 32'h0);
      checkOutput("wrap addr1", sAddr, 32'hFFFF_FFFC);
      applyStimulus(1'b1, 1'b0, 32'h0);
      checkOutput("wrap addr2", sAddr, 32'h0);

      // Unaligned redirect target
      applyStimulus(1'b1, 1'b1, 32'h102);
      applyStimulus(1'b1, 1'b0, 32'h0);
      checkOutput("misalign addr", sAddr, 32'h100);
      checkOutput("misalign pulse", {31'b0, sMis}, {31'b0, ALIGN_CHK});
      applyStimulus(1'b1, 1'b0, 32'h0);
      checkOutput("misalign clear", {31'b0, sMis}, 32'h0);

      // Randomized traffic against the reference model
      for (int i = 0; i < 400; i++) begin
         applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0, $urandom());
      end

      $display("%0d/%0d checks passed", passedChecks, totalChecks);
      $finish;
   end

endmodule
